// File: rtl/btb_fetch_unit_if.sv
// Fetch-unit bus: IF-stage outputs, ID-stage resolution feedback and hazard stall.
// The master modport is the fetch unit; the slave modport is the surrounding pipeline.
interface btb_fetch_unit_if #(
    parameter int WORD_SIZE = 16
);
    logic                 stall;
    logic                 readM1;
    logic [WORD_SIZE-1:0] address1;
    logic [WORD_SIZE-1:0] if_pred_next;
    logic                 if_pred_hit;
    logic                 resolve_valid;
    logic [WORD_SIZE-1:0] resolve_pc;
    logic                 resolve_is_jump;
    logic                 resolve_taken;
    logic [WORD_SIZE-1:0] resolve_target;
    logic [WORD_SIZE-1:0] resolve_pred_next;
    logic                 flush;
    logic [WORD_SIZE-1:0] btb_hits;
    logic [WORD_SIZE-1:0] mispredicts;

    modport master (
        input  stall, resolve_valid, resolve_pc, resolve_is_jump, resolve_taken,
               resolve_target, resolve_pred_next,
        output readM1, address1, if_pred_next, if_pred_hit, flush, btb_hits, mispredicts
    );

    modport slave (
        output stall, resolve_valid, resolve_pc, resolve_is_jump, resolve_taken,
               resolve_target, resolve_pred_next,
        input  readM1, address1, if_pred_next, if_pred_hit, flush, btb_hits, mispredicts
    );
endinterface

// File: rtl/btb_fetch_unit.sv
// Instruction-fetch front end: PC register, direct-mapped BTB with 2-bit counters,
// and ID-stage redirect on mispredict. The BTB is cleared one entry per cycle after reset.
module btb_fetch_unit #(
    parameter int                 WORD_SIZE    = 16,
    parameter int                 BTB_IDX_BITS = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC   = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    btb_fetch_unit_if.master   bus
);
    localparam int ENTRIES  = 1 << BTB_IDX_BITS;
    localparam int TAG_BITS = WORD_SIZE - BTB_IDX_BITS;
    localparam logic [BTB_IDX_BITS-1:0] IDX_LAST = BTB_IDX_BITS'(ENTRIES - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [BTB_IDX_BITS-1:0] r_initIdx;
    logic [WORD_SIZE-1:0]    r_pc;
    logic [WORD_SIZE-1:0]    r_btbHits;
    logic [WORD_SIZE-1:0]    r_mispredicts;

    logic                    r_valid  [ENTRIES];
    logic [TAG_BITS-1:0]     r_tag    [ENTRIES];
    logic [WORD_SIZE-1:0]    r_target [ENTRIES];
    logic [1:0]              r_ctr    [ENTRIES];

    logic [BTB_IDX_BITS-1:0] w_lkIdx;
    logic [TAG_BITS-1:0]     w_lkTag;
    logic                    w_lkHit;
    logic [WORD_SIZE-1:0]    w_pcPlus1;
    logic [BTB_IDX_BITS-1:0] w_rsIdx;
    logic [TAG_BITS-1:0]     w_rsTag;
    logic                    w_rsTagHit;
    logic [WORD_SIZE-1:0]    w_actualNext;
    logic                    w_run;
    logic                    w_predHit;
    logic [WORD_SIZE-1:0]    w_predNext;
    logic                    w_flush;
    logic [WORD_SIZE-1:0]    w_pcNext;

    // Lookup reads the pre-update array, so a same-index update is not bypassed.
    assign w_lkIdx   = r_pc[BTB_IDX_BITS-1:0];
    assign w_lkTag   = r_pc[WORD_SIZE-1:BTB_IDX_BITS];
    assign w_lkHit   = r_valid[w_lkIdx] && (r_tag[w_lkIdx] == w_lkTag) && r_ctr[w_lkIdx][1];
    assign w_pcPlus1 = r_pc + WORD_SIZE'(1);

    assign w_rsIdx      = bus.resolve_pc[BTB_IDX_BITS-1:0];
    assign w_rsTag      = bus.resolve_pc[WORD_SIZE-1:BTB_IDX_BITS];
    assign w_rsTagHit   = r_valid[w_rsIdx] && (r_tag[w_rsIdx] == w_rsTag);
    assign w_actualNext = bus.resolve_taken ? bus.resolve_target
                                            : bus.resolve_pc + WORD_SIZE'(1);

    always_comb begin
        w_stateNext = r_state;
        w_run       = 1'b0;
        w_predHit   = 1'b0;
        w_predNext  = w_pcPlus1;
        w_flush     = 1'b0;
        w_pcNext    = r_pc;
        case (r_state)
            ST_INIT: begin
                if (r_initIdx == IDX_LAST) begin
                    w_stateNext = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run      = 1'b1;
                w_predHit  = w_lkHit;
                w_predNext = w_lkHit ? r_target[w_lkIdx] : w_pcPlus1;
                w_flush    = bus.resolve_valid && (w_actualNext != bus.resolve_pred_next);
                // A redirect wins over a hazard stall: the stalled instruction is squashed anyway.
                if (w_flush) begin
                    w_pcNext = w_actualNext;
                end else if (!bus.stall) begin
                    w_pcNext = w_predNext;
                end
            end
            default: w_stateNext = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_initIdx     <= '0;
            r_btbHits     <= '0;
            r_mispredicts <= '0;
        end else begin
            r_pc <= w_pcNext;
            if (r_state == ST_INIT) begin
                r_initIdx <= r_initIdx + BTB_IDX_BITS'(1);
            end
            if (w_predHit && !bus.stall && !w_flush && !(&r_btbHits)) begin
                r_btbHits <= r_btbHits + WORD_SIZE'(1);
            end
            if (w_flush && !(&r_mispredicts)) begin
                r_mispredicts <= r_mispredicts + WORD_SIZE'(1);
            end
        end
    end

    // The array has no reset of its own; INIT walks every index clearing valid and counter.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_valid[r_initIdx] <= 1'b0;
            r_ctr[r_initIdx]   <= 2'b00;
        end else if (bus.resolve_valid) begin
            if (bus.resolve_taken) begin
                r_target[w_rsIdx] <= bus.resolve_target;
                if (w_rsTagHit) begin
                    if (bus.resolve_is_jump || r_ctr[w_rsIdx] == 2'b11) begin
                        r_ctr[w_rsIdx] <= 2'b11;
                    end else begin
                        r_ctr[w_rsIdx] <= r_ctr[w_rsIdx] + 2'b01;
                    end
                end else begin
                    r_valid[w_rsIdx] <= 1'b1;
                    r_tag[w_rsIdx]   <= w_rsTag;
                    r_ctr[w_rsIdx]   <= bus.resolve_is_jump ? 2'b11 : 2'b10;
                end
            end else if (w_rsTagHit && r_ctr[w_rsIdx] != 2'b00) begin
                r_ctr[w_rsIdx] <= r_ctr[w_rsIdx] - 2'b01;
            end
        end
    end

    assign bus.readM1       = w_run;
    assign bus.address1     = r_pc;
    assign bus.if_pred_hit  = w_predHit;
    assign bus.if_pred_next = w_predNext;
    assign bus.flush        = w_flush;
    assign bus.btb_hits     = r_btbHits;
    assign bus.mispredicts  = r_mispredicts;

endmodule

// File: tb/tb_btb_fetch_unit.sv
// Self-checking bench for btb_fetch_unit: directed redirect/alias/stall/wrap scenarios
// followed by randomized resolution traffic, all checked against a behavioural BTB model.
module tb_btb_fetch_unit;
    localparam int ENTRIES = 16;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    int mPc, mHits, mMisses, mInitLeft;
    int mValid [ENTRIES];
    int mTag   [ENTRIES];
    int mTarget[ENTRIES];
    int mCtr   [ENTRIES];

    logic        lastFlush;
    logic        lastPredHit;
    logic [15:0] lastPredNext;

    btb_fetch_unit_if #(.WORD_SIZE(16)) bus ();

    btb_fetch_unit #(
        .WORD_SIZE   (16),
        .BTB_IDX_BITS(4),
        .RESET_PC    (16'h0000)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int modelHit(input int pc);
        int idx = pc % ENTRIES;
        return (mValid[idx] != 0 && mTag[idx] == pc / ENTRIES && mCtr[idx] >= 2) ? 1 : 0;
    endfunction

    function automatic int modelPredNext(input int pc);
        return (modelHit(pc) != 0) ? mTarget[pc % ENTRIES] : (pc + 1) % 65536;
    endfunction

    function automatic void modelClear();
        for (int i = 0; i < ENTRIES; i++) begin
            mValid[i] = 0; mTag[i] = 0; mTarget[i] = 0; mCtr[i] = 0;
        end
    endfunction

    // Called at a falling edge; drives one cycle of inputs, checks, then advances the model.
    task automatic applyStimulus(input bit st, input bit rv, input int rpc, input bit rj,
                                 input bit rt, input int rtgt, input int rpred);
        bit inRun;
        int eHit, eNext, actual, eFlush, idx, tagHit;
        bus.stall             = st;
        bus.resolve_valid     = rv;
        bus.resolve_pc        = 16'(rpc);
        bus.resolve_is_jump   = rj;
        bus.resolve_taken     = rt;
        bus.resolve_target    = 16'(rtgt);
        bus.resolve_pred_next = 16'(rpred);
        #1;
        inRun  = (mInitLeft == 0);
        eHit   = 0;
        eNext  = 0;
        eFlush = 0;
        actual = rt ? rtgt : (rpc + 1) % 65536;
        checkOutput("readM1", 32'(bus.readM1), 32'(inRun));
        checkOutput("address1", 32'(bus.address1), mPc);
        if (inRun) begin
            eHit   = modelHit(mPc);
            eNext  = modelPredNext(mPc);
            eFlush = (rv && actual != rpred) ? 1 : 0;
            checkOutput("if_pred_hit", 32'(bus.if_pred_hit), eHit);
            checkOutput("if_pred_next", 32'(bus.if_pred_next), eNext);
        end
        checkOutput("flush", 32'(bus.flush), eFlush);
        checkOutput("btb_hits", 32'(bus.btb_hits), mHits);
        checkOutput("mispredicts", 32'(bus.mispredicts), mMisses);
        lastFlush    = bus.flush;
        lastPredHit  = bus.if_pred_hit;
        lastPredNext = bus.if_pred_next;
        @(posedge clk);
        if (!inRun) begin
            mInitLeft--;
        end else begin
            if (eHit != 0 && !st && eFlush == 0 && mHits < 65535) mHits++;
            if (eFlush != 0 && mMisses < 65535) mMisses++;
            mPc = (eFlush != 0) ? actual : (st ? mPc : eNext);
            if (rv) begin
                idx    = rpc % ENTRIES;
                tagHit = (mValid[idx] != 0 && mTag[idx] == rpc / ENTRIES) ? 1 : 0;
                if (rt) begin
                    mTarget[idx] = rtgt;
                    if (tagHit != 0) begin
                        mCtr[idx] = rj ? 3 : ((mCtr[idx] + 1 > 3) ? 3 : mCtr[idx] + 1);
                    end else begin
                        mValid[idx] = 1;
                        mTag[idx]   = rpc / ENTRIES;
                        mCtr[idx]   = rj ? 3 : 2;
                    end
                end else if (tagHit != 0 && mCtr[idx] > 0) begin
                    mCtr[idx]--;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        bus.stall = 1'b0;
        bus.resolve_valid = 1'b0;
        #1;
        checkOutput("rst_readM1", 32'(bus.readM1), 0);
        checkOutput("rst_address1", 32'(bus.address1), 0);
        checkOutput("rst_flush", 32'(bus.flush), 0);
        checkOutput("rst_btb_hits", 32'(bus.btb_hits), 0);
        checkOutput("rst_mispredicts", 32'(bus.mispredicts), 0);
        @(negedge clk);
        reset_n   = 1'b1;
        mPc       = 0;
        mHits     = 0;
        mMisses   = 0;
        mInitLeft = ENTRIES;
        modelClear();
    endtask

    task automatic randomPhase(input int n);
        int rpc, rtgt, rpred;
        bit st, rv, rj, rt;
        for (int i = 0; i < n; i++) begin
            st   = ($urandom_range(0, 3) == 0);
            rv   = ($urandom_range(0, 1) == 1);
            rj   = ($urandom_range(0, 3) == 0);
            rt   = rj ? 1'b1 : ($urandom_range(0, 1) == 1);
            rpc  = ($urandom_range(0, 15) == 0) ? $urandom_range(16'hFFF0, 16'hFFFF)
                                                : $urandom_range(0, 63);
            rtgt = ($urandom_range(0, 15) == 0) ? 16'hFFFF : $urandom_range(0, 63);
            rpred = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63)
                                                : modelPredNext(rpc);
            applyStimulus(st, rv, rpc, rj, rt, rtgt, rpred);
        end
    endtask

    initial begin
        int hitsBefore;
        errors  = 0;
        checks  = 0;
        reset_n = 1'b0;
        bus.stall = 1'b0;
        bus.resolve_valid = 1'b0;
        bus.resolve_pc = '0;
        bus.resolve_is_jump = 1'b0;
        bus.resolve_taken = 1'b0;
        bus.resolve_target = '0;
        bus.resolve_pred_next = '0;
        @(negedge clk);
        doReset();
        for (int i = 0; i < ENTRIES; i++)
            applyStimulus(0, 1, $urandom_range(0, 63), 1, 1, $urandom_range(0, 63), 16'h7777);
        idle(6);

        $display("[TB] branch 0x0005 first taken");
        applyStimulus(0, 1, 16'h0005, 0, 1, 16'h0020, 16'h0006);
        checkOutput("t2_flush", 32'(lastFlush), 1);
        checkOutput("t2_address1", 32'(bus.address1), 16'h0020);
        checkOutput("t2_mispredicts", 32'(bus.mispredicts), 1);
        applyStimulus(0, 1, 16'h0021, 1, 1, 16'h0005, 16'h0022);
        checkOutput("t2_refetch_addr", 32'(bus.address1), 16'h0005);
        checkOutput("t2_refetch_hit", 32'(bus.if_pred_hit), 1);
        checkOutput("t2_refetch_next", 32'(bus.if_pred_next), 16'h0020);

        $display("[TB] branch 0x0005 twice not taken");
        applyStimulus(0, 1, 16'h0005, 0, 0, 16'h0020, 16'h0020);
        checkOutput("t3_flush1", 32'(lastFlush), 1);
        applyStimulus(0, 1, 16'h0005, 0, 0, 16'h0020, 16'h0020);
        checkOutput("t3_flush2", 32'(lastFlush), 1);
        applyStimulus(0, 1, 16'h0021, 1, 1, 16'h0005, 16'h0022);
        checkOutput("t3_addr", 32'(bus.address1), 16'h0005);
        checkOutput("t3_hit", 32'(bus.if_pred_hit), 0);
        checkOutput("t3_next", 32'(bus.if_pred_next), 16'h0006);

        $display("[TB] aliasing jump 0x0013 over 0x0003");
        applyStimulus(0, 1, 16'h0003, 0, 1, 16'h0030, 16'h0004);
        applyStimulus(0, 1, 16'h0013, 1, 1, 16'h0003, 16'h0014);
        checkOutput("t4_addr3", 32'(bus.address1), 16'h0003);
        checkOutput("t4_hit3", 32'(bus.if_pred_hit), 0);
        checkOutput("t4_next3", 32'(bus.if_pred_next), 16'h0004);
        applyStimulus(0, 1, 16'h0007, 1, 1, 16'h0013, 16'h0008);
        checkOutput("t4_addr13", 32'(bus.address1), 16'h0013);
        checkOutput("t4_hit13", 32'(bus.if_pred_hit), 1);
        checkOutput("t4_next13", 32'(bus.if_pred_next), 16'h0003);

        applyStimulus(0, 1, 16'h0013, 1, 1, 16'h0040, 16'h0040);
        checkOutput("t6_no_bypass_next", 32'(lastPredNext), 16'h0003);
        checkOutput("t6_no_bypass_flush", 32'(lastFlush), 0);

        $display("[TB] stall with and without redirect");
        applyStimulus(1, 1, 16'h0008, 0, 1, 16'h0070, 16'h0009);
        checkOutput("t5_flush", 32'(lastFlush), 1);
        checkOutput("t5_addr", 32'(bus.address1), 16'h0070);
        applyStimulus(0, 1, 16'h0007, 1, 1, 16'h0013, 16'h0099);
        hitsBefore = mHits;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0);
            checkOutput("t5_stall_addr", 32'(bus.address1), 16'h0013);
            checkOutput("t5_stall_hits", 32'(bus.btb_hits), hitsBefore);
        end

        $display("[TB] PC wrap");
        applyStimulus(0, 1, 16'h000A, 1, 1, 16'hFFFF, 16'h000B);
        checkOutput("t6_addr_ffff", 32'(bus.address1), 16'hFFFF);
        idle(1);
        checkOutput("t6_wrap", 32'(bus.address1), 16'h0000);

        $display("[TB] random traffic");
        randomPhase(400);

        $display("[TB] reset mid-run");
        doReset();
        for (int i = 0; i < ENTRIES; i++)
            applyStimulus($urandom_range(0, 1), 1, $urandom_range(0, 63), 1, 1, 16'h0010, 16'h5555);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1_fetch_seq", 32'(bus.address1), i);
            checkOutput("t1_hit", 32'(bus.if_pred_hit), 0);
            idle(1);
        end
        checkOutput("t1_hits_zero", 32'(bus.btb_hits), 0);
        checkOutput("t1_misp_zero", 32'(bus.mispredicts), 0);
        randomPhase(150);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
